// File: rtl/sha_msg_padder_pkg.sv
// SHA-256 message padder: shared widths, FSM encoding, padding constants and
// the word-to-bit-position helper used for the 512-bit block layout.
package sha_msg_padder_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BLOCK_W     = 512;
    localparam int unsigned LEN_W       = 64;
    localparam int unsigned PTR_W       = 5;
    localparam int unsigned NUM_WORDS   = 16;
    localparam int unsigned LEN_WORD_HI = 14;
    localparam int unsigned LEN_WORD_LO = 15;

    localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_LEN  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // LSB position of block word j; word 0 sits in the top 32 bits.
    function automatic logic [8:0] idx32_lsb(input logic [3:0] j);
        logic [3:0] w_slot;
        w_slot = 4'd15 - j;
        return {w_slot, 5'd0};
    endfunction

endpackage

// File: rtl/sha_msg_padder_if.sv
// Word-in / block-out handshake bundle of the SHA-256 message padder.
interface sha_msg_padder_if;
    import sha_msg_padder_pkg::*;

    logic                 i_valid;
    logic [WORD_W-1:0]    i_data;
    logic                 i_last;
    logic [1:0]           i_last_bytes;
    logic                 o_ready;
    logic [BLOCK_W-1:0]   o_block;
    logic                 o_block_valid;
    logic                 o_block_last;
    logic                 i_block_ready;

    // Padder side
    modport slave (
        input  i_valid, i_data, i_last, i_last_bytes, i_block_ready,
        output o_ready, o_block, o_block_valid, o_block_last
    );

    // Host / compression-core side
    modport master (
        output i_valid, i_data, i_last, i_last_bytes, i_block_ready,
        input  o_ready, o_block, o_block_valid, o_block_last
    );

endinterface

// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit length.
module sha_msg_padder
    import sha_msg_padder_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    sha_msg_padder_if.slave   bus
);

    state_t               r_state;
    state_t               w_next_state;
    logic [BLOCK_W-1:0]   r_buf;
    logic [BLOCK_W-1:0]   w_buf_nxt;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_ptr_nxt;
    logic [PTR_W-1:0]     w_ptr_inc;
    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     w_len_nxt;
    logic                 r_pad_pend;
    logic                 w_pad_pend_nxt;
    logic                 r_len_owed;
    logic                 w_len_owed_nxt;
    logic                 r_block_valid;
    logic                 r_block_last;
    logic                 w_block_last_nxt;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_short_last;
    logic                 w_room_for_len;
    logic                 w_ptr_full;

    // Keep the k valid leading bytes, insert 0x80 right after them, zero the rest.
    function automatic logic [WORD_W-1:0] pad_last_word(input logic [WORD_W-1:0] data,
                                                        input logic [1:0]        nbytes);
        logic [WORD_W-1:0] w_res;
        case (nbytes)
            2'd1:    w_res = (data & 32'hFF00_0000) | 32'h0080_0000;
            2'd2:    w_res = (data & 32'hFFFF_0000) | 32'h0000_8000;
            2'd3:    w_res = (data & 32'hFFFF_FF00) | 32'h0000_0080;
            default: w_res = data;
        endcase
        return w_res;
    endfunction

    assign w_in_fire      = bus.i_valid && (r_state == ST_FILL);
    assign w_out_fire     = (r_state == ST_OUT) && bus.i_block_ready;
    assign w_ptr_inc      = r_ptr + PTR_W'(1);
    assign w_short_last   = bus.i_last && (bus.i_last_bytes != 2'd0);
    assign w_room_for_len = (w_ptr_inc <= PTR_W'(LEN_WORD_HI));
    assign w_ptr_full     = (w_ptr_inc == PTR_W'(NUM_WORDS));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_FILL;
        else       r_state <= w_next_state;
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_in_fire) begin
                    if (!bus.i_last)      w_next_state = w_ptr_full     ? ST_OUT : ST_FILL;
                    else if (w_short_last) w_next_state = w_room_for_len ? ST_LEN : ST_OUT;
                    else                  w_next_state = w_ptr_full     ? ST_OUT : ST_PAD;
                end
            end
            ST_PAD:  w_next_state = w_room_for_len ? ST_LEN : ST_OUT;
            ST_LEN:  w_next_state = ST_OUT;
            ST_OUT: begin
                if (w_out_fire) begin
                    if (r_pad_pend)      w_next_state = ST_PAD;
                    else if (r_len_owed) w_next_state = ST_LEN;
                    else                 w_next_state = ST_FILL;
                end
            end
            default: w_next_state = ST_FILL;
        endcase
    end

    // Buffer, pointer, length and flag updates per state
    always_comb begin
        w_buf_nxt        = r_buf;
        w_ptr_nxt        = r_ptr;
        w_len_nxt        = r_len;
        w_pad_pend_nxt   = r_pad_pend;
        w_len_owed_nxt   = r_len_owed;
        w_block_last_nxt = r_block_last;
        case (r_state)
            ST_FILL: begin
                if (w_in_fire) begin
                    w_buf_nxt[idx32_lsb(r_ptr[3:0]) +: WORD_W] =
                        w_short_last ? pad_last_word(bus.i_data, bus.i_last_bytes) : bus.i_data;
                    w_ptr_nxt = w_ptr_inc;
                    w_len_nxt = r_len + (w_short_last ? LEN_W'({bus.i_last_bytes, 3'b000})
                                                      : LEN_W'(WORD_W));
                    if (w_short_last && !w_room_for_len)               w_len_owed_nxt = 1'b1;
                    if (bus.i_last && !w_short_last && w_ptr_full)     w_pad_pend_nxt = 1'b1;
                end
            end
            ST_PAD: begin
                w_buf_nxt[idx32_lsb(r_ptr[3:0]) +: WORD_W] = PAD_WORD;
                w_ptr_nxt = w_ptr_inc;
                if (!w_room_for_len) w_len_owed_nxt = 1'b1;
            end
            ST_LEN: begin
                w_buf_nxt[idx32_lsb(4'(LEN_WORD_HI)) +: WORD_W] = r_len[63:32];
                w_buf_nxt[idx32_lsb(4'(LEN_WORD_LO)) +: WORD_W] = r_len[31:0];
                w_block_last_nxt = 1'b1;
            end
            ST_OUT: begin
                if (w_out_fire) begin
                    // Clearing here provides the zero fill of the next block.
                    w_buf_nxt = '0;
                    w_ptr_nxt = '0;
                    if (r_block_last) begin
                        w_len_nxt        = '0;
                        w_pad_pend_nxt   = 1'b0;
                        w_len_owed_nxt   = 1'b0;
                        w_block_last_nxt = 1'b0;
                    end else if (r_pad_pend) begin
                        w_pad_pend_nxt = 1'b0;
                    end else if (r_len_owed) begin
                        w_len_owed_nxt = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and block-output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf         <= '0;
            r_ptr         <= '0;
            r_len         <= '0;
            r_pad_pend    <= 1'b0;
            r_len_owed    <= 1'b0;
            r_block_valid <= 1'b0;
            r_block_last  <= 1'b0;
        end else begin
            r_buf         <= w_buf_nxt;
            r_ptr         <= w_ptr_nxt;
            r_len         <= w_len_nxt;
            r_pad_pend    <= w_pad_pend_nxt;
            r_len_owed    <= w_len_owed_nxt;
            r_block_valid <= (w_next_state == ST_OUT);
            r_block_last  <= w_block_last_nxt;
        end
    end

    // Output decode: input ready is a pure state decode
    always_comb begin
        bus.o_ready = (r_state == ST_FILL);
    end

    assign bus.o_block       = r_buf;
    assign bus.o_block_valid = r_block_valid;
    assign bus.o_block_last  = r_block_last;

endmodule

// File: tb/tb_sha_msg_padder.sv
// Self-checking bench for sha_msg_padder: directed timing/backpressure/reset
// steps plus random messages checked against a byte-level padding model.
module tb_sha_msg_padder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sha_msg_padder_if bus ();

    sha_msg_padder dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    byte unsigned     msg[$];
    logic [511:0]     exp_blk[$];
    bit               exp_last[$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        bus.i_valid       = 1'b0;
        bus.i_data        = '0;
        bus.i_last        = 1'b0;
        bus.i_last_bytes  = 2'd0;
        bus.i_block_ready = 1'b0;
    endtask

    // FIPS 180-4 padding done on bytes, then cut into 64-byte blocks.
    task automatic build_model();
        byte unsigned p[$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        int           nblk;
        p = msg;
        bitlen = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        nblk = p.size() / 64;
        exp_blk.delete();
        exp_last.delete();
        for (int b = 0; b < nblk; b++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
            exp_blk.push_back(blk);
            exp_last.push_back(b == nblk - 1);
        end
    endtask

    task automatic gen_msg(input int nbytes);
        msg.delete();
        for (int i = 0; i < nbytes; i++) msg.push_back(8'($urandom));
    endtask

    // Streams msg with random input gaps and random block backpressure.
    task automatic send_msg(input int bp_pct, input int gap_pct);
        int           nb;
        int           nwords;
        int           wi;
        int           got;
        int           cyc;
        int           idx;
        bit           prev_stall;
        logic [511:0] prev_blk;
        logic         prev_last;
        logic [31:0]  w;
        nb = msg.size();
        nwords = (nb + 3) / 4;
        build_model();
        wi = 0; got = 0; cyc = 0; prev_stall = 1'b0;
        prev_blk = '0; prev_last = 1'b0;
        while (got < exp_blk.size() && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                check("stall_valid_held", bus.o_block_valid, 1'b1);
                check("stall_block_held", bus.o_block, prev_blk);
                check("stall_last_held",  bus.o_block_last, prev_last);
            end
            for (int b = 0; b < 4; b++) begin
                idx = 4*wi + b;
                w[31 - 8*b -: 8] = (idx < nb) ? msg[idx] : 8'($urandom);
            end
            bus.i_data        = w;
            bus.i_valid       = (wi < nwords) && (int'($urandom_range(99)) >= gap_pct);
            bus.i_last        = (wi == nwords - 1);
            bus.i_last_bytes  = 2'(nb % 4);
            bus.i_block_ready = (int'($urandom_range(99)) >= bp_pct);
            if (bus.o_block_valid) check("ready_low_while_valid", bus.o_ready, 1'b0);
            if (bus.o_ready && bus.i_valid) wi++;
            prev_stall = bus.o_block_valid && !bus.i_block_ready;
            prev_blk   = bus.o_block;
            prev_last  = bus.o_block_last;
            if (bus.o_block_valid && bus.i_block_ready) begin
                check($sformatf("len%0d_blk%0d_data", nb, got), bus.o_block, exp_blk[got]);
                check($sformatf("len%0d_blk%0d_last", nb, got), bus.o_block_last, exp_last[got]);
                got++;
            end
        end
        @(negedge clk);
        idle();
        check($sformatf("len%0d_block_count", nb), 512'(got), 512'(exp_blk.size()));
        check($sformatf("len%0d_words_taken", nb), 512'(wi), 512'(nwords));
        check($sformatf("len%0d_ready_after", nb), bus.o_ready, 1'b1);
        check($sformatf("len%0d_valid_after", nb), bus.o_block_valid, 1'b0);
    endtask

    logic [511:0] abc_blk;
    int           dir_lens[13] = '{3, 7, 56, 64, 55, 60, 58, 62, 63, 1, 4, 119, 120};

    initial begin
        abc_blk = '0;
        abc_blk[511:480] = 32'h6162_6380;
        abc_blk[31:0]    = 32'h0000_0018;

        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",       bus.o_ready,       1'b1);
        check("rst_block_valid", bus.o_block_valid, 1'b0);
        check("rst_block_last",  bus.o_block_last,  1'b0);
        check("rst_block",       bus.o_block,       '0);
        rst = 1'b0;

        // "abc": accepted at edge N, LEN at N+1, block visible after N+1
        bus.i_valid      = 1'b1;
        bus.i_data       = 32'h6162_63A5;
        bus.i_last       = 1'b1;
        bus.i_last_bytes = 2'd3;
        @(negedge clk);
        idle();
        check("abc_valid_cycle_n1", bus.o_block_valid, 1'b0);
        check("abc_ready_cycle_n1", bus.o_ready,       1'b0);
        @(negedge clk);
        check("abc_valid_cycle_n2", bus.o_block_valid, 1'b1);
        check("abc_last",           bus.o_block_last,  1'b1);
        check("abc_block",          bus.o_block,       abc_blk);

        // Backpressure: block held, no word accepted
        bus.i_valid = 1'b1;
        bus.i_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", bus.o_block_valid, 1'b1);
            check("bp_block", bus.o_block,       abc_blk);
            check("bp_last",  bus.o_block_last,  1'b1);
            check("bp_ready", bus.o_ready,       1'b0);
        end
        bus.i_valid       = 1'b0;
        bus.i_block_ready = 1'b1;
        @(negedge clk);
        bus.i_block_ready = 1'b0;
        check("accept_ready_next", bus.o_ready,       1'b1);
        check("accept_valid_drop", bus.o_block_valid, 1'b0);

        // Reset mid-message after 7 words, then a clean "abc"
        for (int i = 0; i < 7; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = $urandom;
            bus.i_last  = 1'b0;
            @(negedge clk);
        end
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", bus.o_ready,       1'b1);
        check("midrst_valid", bus.o_block_valid, 1'b0);
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        send_msg(0, 0);
        check("midrst_abc_model", exp_blk[0], abc_blk);

        // Directed lengths covering every padding boundary, back to back
        foreach (dir_lens[i]) begin
            gen_msg(dir_lens[i]);
            send_msg(30, 20);
        end

        // Random messages
        for (int i = 0; i < 15; i++) begin
            gen_msg(int'($urandom_range(1, 200)));
            send_msg(int'($urandom_range(0, 60)), int'($urandom_range(0, 40)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
